// File: rtl/program_memory_arbiter.sv
// Shares the program-memory read port between fetch (priority) and debug (starvation-protected).
// Grants are combinational and data/err return registered one cycle later; a denied requester just holds its request.
module program_memory_arbiter #(
   parameter int                    DATA_WIDTH   = 32,
   parameter int                    MEMORY_DEPTH = 256,
   parameter logic [DATA_WIDTH-1:0] BASE_ADDR    = 'h0040_0000,
   parameter int                    STARVE_LIMIT = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  fetch_req_i,
   input  logic [DATA_WIDTH-1:0] fetch_addr_i,
   input  logic                  fetch_flush_i,
   output logic                  fetch_gnt_o,
   output logic                  fetch_rvalid_o,
   output logic [DATA_WIDTH-1:0] fetch_instr_o,
   output logic                  fetch_err_o,
   input  logic                  dbg_req_i,
   input  logic [DATA_WIDTH-1:0] dbg_addr_i,
   output logic                  dbg_gnt_o,
   output logic                  dbg_rvalid_o,
   output logic [DATA_WIDTH-1:0] dbg_data_o,
   output logic                  dbg_err_o,
   output logic [DATA_WIDTH-1:0] mem_address_o,
   input  logic [DATA_WIDTH-1:0] mem_instruction_i
);

   typedef enum logic [1:0] {IDLE, FETCH, DEBUG} owner_t;

   localparam logic [7:0]            LIMIT = 8'(STARVE_LIMIT);
   localparam logic [DATA_WIDTH-3:0] DEPTH = (DATA_WIDTH-2)'(MEMORY_DEPTH);

   owner_t                state;
   logic [7:0]            starve_cnt;
   logic                  fetch_eligible, force_dbg, fetch_gnt, dbg_gnt, addr_err;
   logic [DATA_WIDTH-1:0] offset, fetch_instr_q, dbg_data_q;
   logic                  fetch_err_q, dbg_err_q;

   always_comb begin
      fetch_eligible = fetch_req_i & ~fetch_flush_i;
      force_dbg      = dbg_req_i & (starve_cnt == LIMIT);
      fetch_gnt      = reset & ~force_dbg & fetch_eligible;
      dbg_gnt        = reset & (force_dbg | (~fetch_eligible & dbg_req_i));
      mem_address_o  = '0;
      if (fetch_gnt)
         mem_address_o = fetch_addr_i;
      else if (dbg_gnt)
         mem_address_o = dbg_addr_i;
      // Addresses below the base wrap to a huge offset and fail the depth compare.
      offset   = mem_address_o - BASE_ADDR;
      addr_err = (mem_address_o[1:0] != 2'b00) | (offset[DATA_WIDTH-1:2] >= DEPTH);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state         <= IDLE;
         starve_cnt    <= '0;
         fetch_instr_q <= '0;
         fetch_err_q   <= 1'b0;
         dbg_data_q    <= '0;
         dbg_err_q     <= 1'b0;
      end else begin
         if (fetch_gnt)
            state <= FETCH;
         else if (dbg_gnt)
            state <= DEBUG;
         else
            state <= IDLE;

         if (dbg_gnt || !dbg_req_i)
            starve_cnt <= '0;
         else if (fetch_gnt && starve_cnt != LIMIT)
            starve_cnt <= starve_cnt + 8'd1;

         if (fetch_gnt) begin
            fetch_instr_q <= addr_err ? '0 : mem_instruction_i;
            fetch_err_q   <= addr_err;
         end
         if (dbg_gnt) begin
            dbg_data_q <= addr_err ? '0 : mem_instruction_i;
            dbg_err_q  <= addr_err;
         end
      end
   end

   // A flush in the response cycle kills the fetch response but leaves the data register loaded.
   assign fetch_gnt_o    = fetch_gnt;
   assign dbg_gnt_o      = dbg_gnt;
   assign fetch_rvalid_o = (state == FETCH) & ~fetch_flush_i;
   assign fetch_err_o    = fetch_rvalid_o & fetch_err_q;
   assign fetch_instr_o  = fetch_instr_q;
   assign dbg_rvalid_o   = (state == DEBUG);
   assign dbg_err_o      = dbg_rvalid_o & dbg_err_q;
   assign dbg_data_o     = dbg_data_q;

endmodule

// File: tb/tb_program_memory_arbiter.sv
// Bench for program_memory_arbiter: directed scenarios plus a randomized run against a cycle model.
module tb_program_memory_arbiter;
   localparam int          LIMIT = 4;
   localparam logic [31:0] BASE  = 32'h0040_0000;

   logic        clk = 1'b0, reset = 1'b0;
   logic        fetch_req = 1'b0, fetch_flush = 1'b0, dbg_req = 1'b0;
   logic [31:0] fetch_addr = '0, dbg_addr = '0;
   logic        fetch_gnt, fetch_rvalid, fetch_err, dbg_gnt, dbg_rvalid, dbg_err;
   logic [31:0] fetch_instr, dbg_data, mem_address, mem_instruction, mem_off;
   logic [31:0] rom [256];

   int checks = 0, failures = 0;
   int m_wait, m_owner;
   logic [31:0] m_data;
   logic        m_err;

   program_memory_arbiter #(.DATA_WIDTH(32), .MEMORY_DEPTH(256), .BASE_ADDR(BASE), .STARVE_LIMIT(LIMIT)) dut (
      .clk(clk), .reset(reset),
      .fetch_req_i(fetch_req), .fetch_addr_i(fetch_addr), .fetch_flush_i(fetch_flush),
      .fetch_gnt_o(fetch_gnt), .fetch_rvalid_o(fetch_rvalid), .fetch_instr_o(fetch_instr),
      .fetch_err_o(fetch_err), .dbg_req_i(dbg_req), .dbg_addr_i(dbg_addr), .dbg_gnt_o(dbg_gnt),
      .dbg_rvalid_o(dbg_rvalid), .dbg_data_o(dbg_data), .dbg_err_o(dbg_err),
      .mem_address_o(mem_address), .mem_instruction_i(mem_instruction)
   );

   always #5 clk = ~clk;

   // Memory returns rom contents even for bad addresses, so the DUT must zero them itself.
   always_comb begin
      mem_off         = mem_address - BASE;
      mem_instruction = rom[mem_off[9:2]];
   end

   function automatic logic bad_addr(input logic [31:0] a);
      logic [31:0] o;
      o = a - BASE;
      return (a[1:0] != 2'b00) || (o / 4 >= 32'd256);
   endfunction

   function automatic logic [31:0] rom_at(input logic [31:0] a);
      logic [31:0] o;
      o = a - BASE;
      return rom[o[9:2]];
   endfunction

   function automatic logic [31:0] rand_addr();
      if ($urandom_range(0, 9) != 0) return BASE + 4 * $urandom_range(0, 255);
      return $urandom();
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_idle();
      fetch_req = 1'b0; dbg_req = 1'b0; fetch_flush = 1'b0;
      tick();
   endtask

   task automatic test_reset();
      repeat (2) @(posedge clk);
      #2;
      checks++;
      if ({fetch_gnt, dbg_gnt, fetch_rvalid, dbg_rvalid, fetch_err, dbg_err} !== 6'b0 ||
          fetch_instr !== 32'h0 || dbg_data !== 32'h0 || mem_address !== 32'h0) begin
         failures++;
         $display("FAIL reset_state got gnt=%b%b rv=%b%b err=%b%b fi=%h dd=%h ma=%h exp all zero",
                  fetch_gnt, dbg_gnt, fetch_rvalid, dbg_rvalid, fetch_err, dbg_err, fetch_instr, dbg_data, mem_address);
      end
      @(negedge clk);
      reset = 1'b1;
      tick();
   endtask

   task automatic test_fetch_seq();
      for (int i = 0; i < 4; i++) begin
         fetch_req  = (i < 3);
         fetch_addr = BASE + 32'(4 * i);
         #1;
         if (i < 3) begin
            checks++;
            if (fetch_gnt !== 1'b1 || mem_address !== BASE + 32'(4 * i)) begin
               failures++;
               $display("FAIL seq_gnt[%0d] got gnt=%b addr=%h exp gnt=1 addr=%h", i, fetch_gnt, mem_address, BASE + 32'(4 * i));
            end
         end
         if (i > 0) begin
            checks++;
            if (fetch_rvalid !== 1'b1 || fetch_instr !== rom[i-1] || fetch_err !== 1'b0) begin
               failures++;
               $display("FAIL seq_rsp[%0d] got rv=%b d=%h err=%b exp rv=1 d=%h err=0", i, fetch_rvalid, fetch_instr, fetch_err, rom[i-1]);
            end
         end
         tick();
      end
      set_idle();
   endtask

   task automatic test_starvation();
      for (int k = 0; k < 15; k++) begin
         fetch_req = 1'b1; fetch_addr = BASE; dbg_req = 1'b1; dbg_addr = BASE + 32'd8;
         #1;
         checks++;
         if (fetch_gnt !== (k % 5 != 4) || dbg_gnt !== (k % 5 == 4)) begin
            failures++;
            $display("FAIL starve_gnt[%0d] got f=%b d=%b exp f=%b d=%b", k, fetch_gnt, dbg_gnt, k % 5 != 4, k % 5 == 4);
         end
         if (k > 0) begin
            checks++;
            if (dbg_rvalid !== ((k - 1) % 5 == 4) || fetch_rvalid !== ((k - 1) % 5 != 4) ||
                (dbg_rvalid === 1'b1 && dbg_data !== rom[2])) begin
               failures++;
               $display("FAIL starve_rsp[%0d] got drv=%b frv=%b dd=%h exp drv=%b frv=%b dd=%h",
                        k, dbg_rvalid, fetch_rvalid, dbg_data, (k - 1) % 5 == 4, (k - 1) % 5 != 4, rom[2]);
            end
         end
         tick();
      end
      set_idle();
      set_idle();
   endtask

   task automatic test_errors();
      logic [31:0] addrs [3];
      addrs[0] = BASE + 32'd2; addrs[1] = BASE + 32'h400; addrs[2] = 32'h0;
      for (int i = 0; i < 4; i++) begin
         fetch_req = (i < 3);
         if (i < 3) fetch_addr = addrs[i];
         #1;
         if (i < 3) begin
            checks++;
            if (fetch_gnt !== 1'b1) begin
               failures++;
               $display("FAIL err_gnt[%0d] got=%b exp=1", i, fetch_gnt);
            end
         end
         if (i > 0) begin
            checks++;
            if (fetch_rvalid !== 1'b1 || fetch_err !== 1'b1 || fetch_instr !== 32'h0) begin
               failures++;
               $display("FAIL err_rsp[%0d] got rv=%b err=%b d=%h exp rv=1 err=1 d=0", i, fetch_rvalid, fetch_err, fetch_instr);
            end
         end
         tick();
      end
      set_idle();
   endtask

   task automatic test_flush();
      fetch_req = 1'b1; fetch_addr = BASE + 32'd12;
      #1;
      checks++;
      if (fetch_gnt !== 1'b1) begin failures++; $display("FAIL flush_n_gnt got=%b exp=1", fetch_gnt); end
      tick();
      fetch_flush = 1'b1; dbg_req = 1'b1; dbg_addr = BASE + 32'd16;
      #1;
      checks++;
      if (fetch_rvalid !== 1'b0 || fetch_err !== 1'b0 || fetch_gnt !== 1'b0 || dbg_gnt !== 1'b1 || mem_address !== BASE + 32'd16) begin
         failures++;
         $display("FAIL flush_n1 got frv=%b ferr=%b fg=%b dg=%b ma=%h exp 0 0 0 1 %h",
                  fetch_rvalid, fetch_err, fetch_gnt, dbg_gnt, mem_address, BASE + 32'd16);
      end
      tick();
      fetch_req = 1'b0; fetch_flush = 1'b0; dbg_req = 1'b0;
      #1;
      checks++;
      if (dbg_rvalid !== 1'b1 || dbg_data !== rom[4] || fetch_rvalid !== 1'b0) begin
         failures++;
         $display("FAIL flush_n2 got drv=%b dd=%h frv=%b exp 1 %h 0", dbg_rvalid, dbg_data, fetch_rvalid, rom[4]);
      end
      tick();
   endtask

   task automatic test_reset_mid_read();
      dbg_req = 1'b1; dbg_addr = BASE + 32'd20;
      #1;
      checks++;
      if (dbg_gnt !== 1'b1) begin failures++; $display("FAIL rmid_gnt got=%b exp=1", dbg_gnt); end
      tick();
      dbg_req = 1'b0;
      #1;
      reset = 1'b0;
      #1;
      checks++;
      if (dbg_rvalid !== 1'b0 || dbg_data !== 32'h0 || fetch_rvalid !== 1'b0 || fetch_instr !== 32'h0 || dbg_gnt !== 1'b0) begin
         failures++;
         $display("FAIL rmid_in_reset got drv=%b dd=%h frv=%b fi=%h dg=%b exp all zero", dbg_rvalid, dbg_data, fetch_rvalid, fetch_instr, dbg_gnt);
      end
      @(posedge clk);
      #3;
      reset = 1'b1;
      for (int i = 0; i < 2; i++) begin
         #1;
         checks++;
         if (dbg_rvalid !== 1'b0 || fetch_rvalid !== 1'b0) begin
            failures++;
            $display("FAIL rmid_after[%0d] got drv=%b frv=%b exp 0 0", i, dbg_rvalid, fetch_rvalid);
         end
         tick();
      end
      dbg_req = 1'b1; dbg_addr = BASE + 32'd24;
      #1;
      checks++;
      if (dbg_gnt !== 1'b1) begin failures++; $display("FAIL rmid_next_gnt got=%b exp=1", dbg_gnt); end
      tick();
      dbg_req = 1'b0;
      #1;
      checks++;
      if (dbg_rvalid !== 1'b1 || dbg_data !== rom[6] || dbg_err !== 1'b0) begin
         failures++;
         $display("FAIL rmid_next_rsp got rv=%b d=%h err=%b exp 1 %h 0", dbg_rvalid, dbg_data, dbg_err, rom[6]);
      end
      tick();
   endtask

   task automatic test_idle();
      for (int k = 0; k < 11; k++) begin
         fetch_req = (k < 3 || k >= 6); dbg_req = fetch_req;
         fetch_addr = BASE; dbg_addr = BASE + 32'd4;
         #1;
         if (k >= 3 && k < 6) begin
            checks++;
            if (fetch_gnt !== 1'b0 || dbg_gnt !== 1'b0 || mem_address !== 32'h0) begin
               failures++;
               $display("FAIL idle[%0d] got fg=%b dg=%b ma=%h exp 0 0 0", k, fetch_gnt, dbg_gnt, mem_address);
            end
         end else if (k >= 6) begin
            checks++;
            if (fetch_gnt !== (k != 10) || dbg_gnt !== (k == 10)) begin
               failures++;
               $display("FAIL idle_cnt_clear[%0d] got fg=%b dg=%b exp %b %b", k, fetch_gnt, dbg_gnt, k != 10, k == 10);
            end
         end
         tick();
      end
      set_idle();
   endtask

   task automatic test_random();
      logic        fe, frc, efg, edg, efrv;
      logic [31:0] eaddr;
      set_idle();
      m_wait = 0; m_owner = 0; m_data = '0; m_err = 1'b0;
      for (int c = 0; c < 400; c++) begin
         fetch_req   = ($urandom_range(0, 3) != 0);
         dbg_req     = ($urandom_range(0, 2) != 0);
         fetch_flush = ($urandom_range(0, 7) == 0);
         fetch_addr  = rand_addr();
         dbg_addr    = rand_addr();
         #1;
         efrv = (m_owner == 1) && !fetch_flush;
         checks++;
         if (fetch_rvalid !== efrv || dbg_rvalid !== (m_owner == 2) ||
             fetch_err !== (efrv && m_err) || dbg_err !== (m_owner == 2 && m_err) ||
             (efrv && fetch_instr !== m_data) || (m_owner == 2 && dbg_data !== m_data)) begin
            failures++;
            $display("FAIL rnd_rsp[%0d] got frv=%b drv=%b ferr=%b derr=%b fi=%h dd=%h exp owner=%0d frv=%b err=%b d=%h",
                     c, fetch_rvalid, dbg_rvalid, fetch_err, dbg_err, fetch_instr, dbg_data, m_owner, efrv, m_err, m_data);
         end
         fe    = fetch_req && !fetch_flush;
         frc   = dbg_req && (m_wait >= LIMIT);
         efg   = fe && !frc;
         edg   = dbg_req && !efg;
         eaddr = efg ? fetch_addr : (edg ? dbg_addr : 32'h0);
         checks++;
         if (fetch_gnt !== efg || dbg_gnt !== edg || mem_address !== eaddr) begin
            failures++;
            $display("FAIL rnd_gnt[%0d] got fg=%b dg=%b ma=%h exp fg=%b dg=%b ma=%h", c, fetch_gnt, dbg_gnt, mem_address, efg, edg, eaddr);
         end
         if (edg || !dbg_req) m_wait = 0;
         else if (m_wait < LIMIT) m_wait++;
         m_owner = efg ? 1 : (edg ? 2 : 0);
         m_err   = bad_addr(eaddr);
         m_data  = m_err ? 32'h0 : rom_at(eaddr);
         tick();
      end
      set_idle();
   endtask

   initial begin
      for (int i = 0; i < 256; i++) rom[i] = $urandom();
      test_reset();
      test_fetch_seq();
      test_starvation();
      test_errors();
      test_flush();
      test_reset_mid_read();
      test_idle();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
